polynomial_decoder: RTL

Inverse of the polynomial encoder. Reads a packed byte stream (7 bytes per 4 coefficients, 14 bits each, little-endian bit packing) from byte RAM. Unpacks each group into 4 coefficients and writes them, zero-extended to 16 bits, into poly RAM. Sits on the decapsulation/key-parse path, so a received public key or ciphertext polynomial can be loaded for NTT/arithmetic.

---
 rtl/newhope_pkg.sv | 29 ++
 rtl/coeff_unpacker.sv | 23 ++
 rtl/polynomial_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/newhope_pkg.sv
// Shared constants for the polynomial pack/unpack path: ring size, coefficient
// widths, packing geometry, derived address widths and the decoder state codes.
package newhope_pkg;

    localparam int N                = 512;
    localparam int Q                = 12289;
    localparam int COEFF_W          = 14;
    localparam int POLY_W           = 16;
    localparam int BYTES_PER_GROUP  = 7;
    localparam int COEFFS_PER_GROUP = 4;

    // One group is 7 bytes carrying exactly 4 x 14-bit coefficients.
    localparam int GROUP_W = BYTES_PER_GROUP * 8;

    localparam int BYTE_AW = $clog2(N * BYTES_PER_GROUP / COEFFS_PER_GROUP);
    localparam int POLY_AW = $clog2(N);

    // Decoder FSM encoding.
    localparam int STATE_W = 3;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_WRITE0 = 3'd3;
    localparam logic [2:0] S_WRITE1 = 3'd4;
    localparam logic [2:0] S_WRITE2 = 3'd5;
    localparam logic [2:0] S_WRITE3 = 3'd6;
    localparam logic [2:0] S_FINAL  = 3'd7;

endpackage

// File: rtl/coeff_unpacker.sv
// Splits one 7-byte group (byte j at bits [8j+7:8j]) into four 14-bit
// coefficients. The packing is little-endian at bit level, so coefficient k
// is simply bits [14k+13:14k] of the group:
//   r0 = a0 | (a1 & 0x3F) << 8
//   r1 = a1 >> 6 | a2 << 2 | (a3 & 0x0F) << 10
//   r2 = a3 >> 4 | a4 << 4 | (a5 & 0x03) << 12
//   r3 = a5 >> 2 | a6 << 6
module coeff_unpacker
    import newhope_pkg::*;
(
    input  logic [GROUP_W-1:0] group_bytes,
    output logic [COEFF_W-1:0] c0,
    output logic [COEFF_W-1:0] c1,
    output logic [COEFF_W-1:0] c2,
    output logic [COEFF_W-1:0] c3
);

    assign c0 = group_bytes[0*COEFF_W +: COEFF_W];
    assign c1 = group_bytes[1*COEFF_W +: COEFF_W];
    assign c2 = group_bytes[2*COEFF_W +: COEFF_W];
    assign c3 = group_bytes[3*COEFF_W +: COEFF_W];

endmodule

// File: rtl/polynomial_decoder.sv
// Reads a packed coefficient stream from byte RAM (7 bytes per 4 coefficients)
// and writes the unpacked, zero-extended coefficients into poly RAM.
//
// Control handshake: start is a request sampled only while idle; once taken,
// busy rises the next cycle and stays high through the done cycle; start is
// ignored while busy; done is a single-cycle pulse after the last write.
//
// Per group g (12 cycles): 7 READ cycles issue byte addresses, one WAIT cycle
// catches the last byte out of the 1-cycle-latency RAM, then 4 WRITE cycles.
module polynomial_decoder #(
    parameter int N         = newhope_pkg::N,
    parameter int BYTE_BASE = 0,
    parameter int POLY_BASE = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [newhope_pkg::BYTE_AW-1:0]     byte_addr,
    input  logic [7:0]                          byte_do,
    output logic                                poly_we,
    output logic [newhope_pkg::POLY_AW-1:0]     poly_addra,
    output logic [newhope_pkg::POLY_W-1:0]      poly_dia,
    output logic [newhope_pkg::STATE_W-1:0]     state_dbg
);
    import newhope_pkg::*;

    localparam int G  = N / COEFFS_PER_GROUP;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [2:0]    IDX_LAST = 3'(BYTES_PER_GROUP - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);

    logic [2:0]         state;
    logic [2:0]         idx;
    logic [GW-1:0]      grp;
    logic [GROUP_W-1:0] shreg;
    logic [GROUP_W-1:0] shreg_nxt;
    logic               capture;
    logic [COEFF_W-1:0] c0, c1, c2, c3;

    assign state_dbg = state;

    // Byte j arrives one cycle after its address, so capture on READ j>=1 and
    // on WAIT; bytes shift in from the top so byte 0 ends up at bits [7:0].
    always_comb begin
        capture   = ((state == S_READ) && (idx != 3'd0)) || (state == S_WAIT);
        shreg_nxt = shreg;
        if (capture) begin
            shreg_nxt = {byte_do, shreg[GROUP_W-1:8]};
        end
    end

    // The unpacker looks at the next shift-register value so that the byte
    // captured in WAIT is already visible when WRITE0's data is registered.
    coeff_unpacker u_unpack (
        .group_bytes (shreg_nxt),
        .c0          (c0),
        .c1          (c1),
        .c2          (c2),
        .c3          (c3)
    );

    // Main sequencer: byte address generation, capture and coefficient writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            grp        <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_addr  <= '0;
            poly_we    <= 1'b0;
            poly_addra <= '0;
            poly_dia   <= '0;
        end else begin
            done    <= 1'b0;
            poly_we <= 1'b0;
            shreg   <= shreg_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_READ;
                        busy      <= 1'b1;
                        idx       <= 3'd0;
                        grp       <= '0;
                        byte_addr <= BYTE_AW'(BYTE_BASE);
                    end
                end
                S_READ: begin
                    if (idx == IDX_LAST) begin
                        state <= S_WAIT;
                    end else begin
                        idx       <= idx + 3'd1;
                        byte_addr <= byte_addr + BYTE_AW'(1);
                    end
                end
                S_WAIT: begin
                    state      <= S_WRITE0;
                    poly_we    <= 1'b1;
                    poly_addra <= POLY_AW'(POLY_BASE) + POLY_AW'({grp, 2'b00});
                    poly_dia   <= {{(POLY_W-COEFF_W){1'b0}}, c0};
                end
                S_WRITE0: begin
                    state      <= S_WRITE1;
                    poly_we    <= 1'b1;
                    poly_addra <= poly_addra + POLY_AW'(1);
                    poly_dia   <= {{(POLY_W-COEFF_W){1'b0}}, c1};
                end
                S_WRITE1: begin
                    state      <= S_WRITE2;
                    poly_we    <= 1'b1;
                    poly_addra <= poly_addra + POLY_AW'(1);
                    poly_dia   <= {{(POLY_W-COEFF_W){1'b0}}, c2};
                end
                S_WRITE2: begin
                    state      <= S_WRITE3;
                    poly_we    <= 1'b1;
                    poly_addra <= poly_addra + POLY_AW'(1);
                    poly_dia   <= {{(POLY_W-COEFF_W){1'b0}}, c3};
                end
                S_WRITE3: begin
                    if (grp == GRP_LAST) begin
                        state <= S_FINAL;
                        done  <= 1'b1;
                        grp   <= '0;
                    end else begin
                        state     <= S_READ;
                        idx       <= 3'd0;
                        grp       <= grp + GW'(1);
                        byte_addr <= byte_addr + BYTE_AW'(1);
                    end
                end
                S_FINAL: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
